// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and stream framing constants.
package imem_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        LEN_HI = 3'd0,  // waiting for word-count MSB
        LEN_LO = 3'd1,  // waiting for word-count LSB
        DATA   = 3'd2,  // receiving instruction bytes
        RUN    = 3'd3,  // image loaded, processor released
        ERR    = 3'd4   // header asked for more words than fit
    } state_e;

    // Number of bytes in the word-count header.
    localparam int HDR_BYTES      = 2;
    // Bytes per instruction word, sent MSB first.
    localparam int BYTES_PER_WORD = 4;

    // Word-count header is 16 bits wide; widen a depth constant to match.
    function automatic logic [15:0] depth_to_len(input int depth);
        return 16'(depth);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: collects accepted bytes MSB first and flags the
// byte that completes a 32-bit word. The completed word is presented
// combinationally alongside that final byte so the caller can register it.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shreg_q;
    logic [23:0] shreg_d;
    logic [1:0]  byte_cnt_q;
    logic [1:0]  byte_cnt_d;

    // Next-state: shift in accepted bytes, hold while idle, flush on clear.
    always_comb begin
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            shreg_d    = 24'd0;
            byte_cnt_d = 2'd0;
        end else if (accept) begin
            shreg_d    = {shreg_q[15:0], byte_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    // Completed word is the three held bytes plus the one arriving now.
    always_comb begin
        word       = {shreg_q, byte_in};
        word_valid = accept && !clear && (byte_cnt_q == LAST_BYTE);
    end

    // Packer state register; a reset drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= 24'd0;
            byte_cnt_q <= 2'd0;
        end else begin
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed big-endian byte
// stream, writes each word into instruction memory and keeps the processor
// in reset until the whole image has landed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [15:0]     DEPTH_LEN = depth_to_len(DEPTH);
    // Word index carries one extra bit so a full DEPTH-word image can be
    // counted to DEPTH without wrapping before the end-of-image compare.
    localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W + 1)'(1);

    state_e              state_q;
    state_e              state_d;
    logic [15:0]         len_q;
    logic [15:0]         len_d;
    logic [ADDR_W:0]     word_idx_q;
    logic [ADDR_W:0]     word_idx_d;
    logic [ADDR_W:0]     word_idx_inc;
    logic                imem_we_q;
    logic                imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [ADDR_W-1:0]   imem_addr_d;
    logic [31:0]         imem_wdata_q;
    logic [31:0]         imem_wdata_d;
    logic                cpu_reset_q;
    logic                cpu_reset_d;
    logic                done_q;
    logic                done_d;
    logic                error_q;
    logic                error_d;

    logic                accept;
    logic                pk_accept;
    logic                pk_clear;
    logic [31:0]         pk_word;
    logic                pk_word_valid;
    logic [15:0]         hdr_len;

    // Handshake: bytes are taken only while parsing header or payload.
    always_comb begin
        in_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
        accept    = in_valid && in_ready;
        pk_accept = accept && (state_q == DATA);
        hdr_len   = {len_q[15:8], in_data};
    end

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst_n      (reset),
        .clear      (pk_clear),
        .byte_in    (in_data),
        .accept     (pk_accept),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    // FSM next-state, write-port and processor-control decode.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        word_idx_inc = word_idx_q + IDX_ONE;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = 1'b1;
        done_d       = 1'b0;
        pk_clear     = 1'b0;

        case (state_q)
            LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = hdr_len;
                    if (hdr_len > DEPTH_LEN) begin
                        state_d = ERR;
                    end else if (hdr_len == 16'd0) begin
                        state_d = RUN;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = '0;
                        pk_clear   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (pk_word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_idx_q[ADDR_W-1:0];
                    imem_wdata_d = pk_word;
                    word_idx_d   = word_idx_inc;
                    if (16'(word_idx_inc) == len_q) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (restart) begin
                    state_d    = LEN_HI;
                    len_d      = 16'd0;
                    word_idx_d = '0;
                    pk_clear   = 1'b1;
                end else begin
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = LEN_HI;
            end
        endcase

        // Error is sticky because ERR is only left through reset.
        error_d = (state_d == ERR);
    end

    // State and output registers; reset discards any load in progress but
    // leaves the instruction memory itself untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LEN_HI;
            len_q        <= 16'd0;
            word_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Drive ports straight from flops so the memory and processor see
    // glitch-free controls.
    always_comb begin
        imem_we    = imem_we_q;
        imem_addr  = imem_addr_q;
        imem_wdata = imem_wdata_q;
        cpu_reset  = cpu_reset_q;
        done       = done_q;
        error      = error_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          double_we = 0;
    logic        we_prev   = 1'b0;

    logic [7:0]  stream1 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                                  8'h01, 8'h20, 8'h09, 8'h00, 8'h0A};

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse and flag any pulse lasting two cycles.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (we_prev === 1'b1) double_we++;
        end
        we_prev = imem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one byte; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = (in_ready === 1'b1);
            tick();
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_restart();
        in_valid = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    function automatic logic [31:0] full_word(input int i);
        logic [7:0] a;
        a = 8'(i);
        return {a, ~a, 8'hC3, 8'(i * 3)};
    endfunction

    initial begin
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        restart  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        tick();

        // Nominal load at full rate
        clear_log();
        for (int i = 0; i < 6; i++) send_byte(stream1[i]);
        check("t1_we0", 32'(imem_we), 32'd1);
        check("t1_addr0", 32'(imem_addr), 32'd0);
        check("t1_data0", imem_wdata, 32'h20080001);
        for (int i = 6; i < 10; i++) send_byte(stream1[i]);
        check("t1_we1", 32'(imem_we), 32'd1);
        check("t1_addr1", 32'(imem_addr), 32'd1);
        check("t1_data1", imem_wdata, 32'h2009000A);
        check("t1_done_early", 32'(done), 32'd0);
        check("t1_cpurst_early", 32'(cpu_reset), 32'd1);
        idle(1);
        check("t1_we_off", 32'(imem_we), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpurst", 32'(cpu_reset), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd0);
        check("t1_addr_hold", 32'(imem_addr), 32'd1);
        check("t1_data_hold", imem_wdata, 32'h2009000A);
        check("t1_nwrites", 32'(wr_addr.size()), 32'd2);

        // Restart from RUN, then throttled reload of the same image
        pulse_restart();
        check("t2_restart_cpurst", 32'(cpu_reset), 32'd1);
        check("t2_restart_done", 32'(done), 32'd0);
        check("t2_restart_ready", 32'(in_ready), 32'd1);
        clear_log();
        for (int i = 0; i < 10; i++) begin
            send_byte(stream1[i]);
            idle(1);
            if (i == 7) idle(5);
        end
        check("t2_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t2_addr0", 32'(wr_addr[0]), 32'd0);
            check("t2_data0", wr_data[0], 32'h20080001);
            check("t2_addr1", 32'(wr_addr[1]), 32'd1);
            check("t2_data1", wr_data[1], 32'h2009000A);
        end
        check("t2_done", 32'(done), 32'd1);

        // Restart, DEADBEEF load with a restart pulse during DATA
        pulse_restart();
        check("t6_cpurst", 32'(cpu_reset), 32'd1);
        clear_log();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_restart();
        check("t6_ready_after_stray_restart", 32'(in_ready), 32'd1);
        check("t6_cpurst_data", 32'(cpu_reset), 32'd1);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check("t6_we", 32'(imem_we), 32'd1);
        check("t6_addr", 32'(imem_addr), 32'd0);
        check("t6_data", imem_wdata, 32'hDEADBEEF);
        idle(1);
        check("t6_done", 32'(done), 32'd1);
        check("t6_nwrites", 32'(wr_addr.size()), 32'd1);

        // Zero-length image
        pulse_restart();
        clear_log();
        send_byte(8'h00);
        send_byte(8'h00);
        check("t4_done_early", 32'(done), 32'd0);
        idle(1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_cpurst", 32'(cpu_reset), 32'd0);
        check("t4_nwrites", 32'(wr_addr.size()), 32'd0);

        // Asynchronous reset in the middle of word 0
        pulse_restart();
        clear_log();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t5_we", 32'(imem_we), 32'd0);
        check("t5_addr", 32'(imem_addr), 32'd0);
        check("t5_wdata", imem_wdata, 32'd0);
        check("t5_cpurst", 32'(cpu_reset), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t5_no_stray_write", 32'(wr_addr.size()), 32'd0);
        send_word(32'h0001_1122);
        send_byte(8'h33);
        send_byte(8'h44);
        idle(1);
        check("t5_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t5_addr0", 32'(wr_addr[0]), 32'd0);
            check("t5_data0", wr_data[0], 32'h11223344);
        end

        // Oversized header 0x0041
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_log();
        send_byte(8'h00);
        send_byte(8'h41);
        check("t3_error", 32'(error), 32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_cpurst", 32'(cpu_reset), 32'd1);
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (6) tick();
        pulse_restart();
        idle(2);
        check("t3_error_sticky", 32'(error), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_nwrites", 32'(wr_addr.size()), 32'd0);

        // Full-depth image, 64 words
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_log();
        send_byte(8'h00);
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) send_word(full_word(i));
        check("t3f_last_addr", 32'(imem_addr), 32'd63);
        check("t3f_last_data", imem_wdata, full_word(63));
        check("t3f_done_early", 32'(done), 32'd0);
        idle(1);
        check("t3f_done", 32'(done), 32'd1);
        check("t3f_error", 32'(error), 32'd0);
        check("t3f_nwrites", 32'(wr_addr.size()), 32'd64);
        if (wr_addr.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                check($sformatf("t3f_addr%0d", i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("t3f_data%0d", i), wr_data[i], full_word(i));
            end
        end

        check("we_single_cycle", 32'(double_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
